// File: rtl/vc_control_pkg.sv
// ---------------------------------------------------------------------------
// vc_control_pkg
//   Shared types for the victim-cache controller. It fixes the geometry of
//   the 8-way fully-associative victim cache and defines the controller state
//   encoding. It also provides a helper that extracts the least-recently-used
//   way from the datapath's LRU stack.
// ---------------------------------------------------------------------------
package vc_control_pkg;

  localparam int VC_WAYS     = 8;
  localparam int VC_LRU_BITS = 24;   // 8 ways x 3-bit way numbers, MRU first

  typedef logic [2:0] vc_way_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_HIT_UPD,
    S_READ_MEM,
    S_WRITEBACK,
    S_INSERT
  } vc_state_t;

  // The LRU stack holds way numbers from MRU (top) to LRU (bottom). The
  // replacement victim is therefore always the bottom entry.
  function automatic vc_way_t lru_way(input logic [VC_LRU_BITS-1:0] lru_stack);
    return lru_stack[2:0];
  endfunction

endpackage

// File: rtl/vc_control.sv
// ---------------------------------------------------------------------------
// vc_control
//   Sequencing controller for the victim cache that sits between L2 and
//   physical memory. It services two kinds of L2 requests:
//     - Read lookups. A hit returns victim-cache data. A miss is forwarded to
//       memory and is not allocated in the victim cache.
//     - Evictions (clean or dirty). The evicted line is inserted into the
//       victim cache. Inserting into a dirty LRU way first writes that way
//       back to memory.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   l2_read/l2_write  L2 request; each is held until vc_resp
//   l2_dirty          dirty flag of the evicted line
//   vc_resp           one-cycle completion pulse to L2
//   vc_rdata_sel      L2 read data source (0 hit way, 1 pmem)
//   VC_hit, VC_hit_dirty, hit_way   tag-match results from the datapath
//   VC_LRU_dirty      dirty bit of the way currently selected by data_index
//   LRU_out           LRU stack ([23:21] MRU way ... [2:0] LRU way)
//   data_index        way select to the datapath
//   load_VC, load_VC_dirty, VC_dirty_bit, load_LRU   datapath write controls
//   pmem_read/pmem_write/pmem_adr_sel, pmem_resp     memory handshake
// ---------------------------------------------------------------------------
module vc_control
  import vc_control_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  // L2 side
  input  logic                   l2_read,
  input  logic                   l2_write,
  input  logic                   l2_dirty,
  output logic                   vc_resp,
  output logic                   vc_rdata_sel,
  // Datapath status
  input  logic                   VC_hit,
  input  logic                   VC_hit_dirty,
  input  logic                   VC_LRU_dirty,
  input  logic [2:0]             hit_way,
  input  logic [VC_LRU_BITS-1:0] LRU_out,
  // Datapath control
  output logic [2:0]             data_index,
  output logic                   load_VC,
  output logic                   load_VC_dirty,
  output logic                   VC_dirty_bit,
  output logic                   load_LRU,
  // Physical memory
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic                   pmem_adr_sel,
  input  logic                   pmem_resp
);

  vc_state_t state, state_next;

  logic    op_write_q;     // current request is an eviction (else a read)
  vc_way_t hit_way_q;      // way matched during LOOKUP
  logic    hit_dirty_q;    // dirty bit of that way at LOOKUP
  vc_way_t victim_way_q;   // LRU way captured at LOOKUP

  // The op type is captured when the request is accepted, because LOOKUP
  // needs it to choose the next state. An eviction wins over a read that is
  // asserted in the same cycle. That read stays pending and is picked up
  // after the eviction's vc_resp.
  // NOTE: state registers use non-blocking assignments so that every flop
  // samples pre-edge values, regardless of statement order.
  // NOTE: all control registers are reset here. The way arrays live in the
  // datapath and are deliberately left unreset, because valid bits alone
  // decide hits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      op_write_q   <= 1'b0;
      hit_way_q    <= '0;
      hit_dirty_q  <= 1'b0;
      victim_way_q <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && (l2_write || l2_read)) begin
        op_write_q <= l2_write;
      end
      if (state == S_LOOKUP) begin
        hit_way_q    <= hit_way;
        hit_dirty_q  <= VC_hit_dirty;
        victim_way_q <= lru_way(LRU_out);
      end
    end
  end

  // NOTE: every output and the next state get a default before the case, so
  // no path through this block can infer a latch.
  always_comb begin
    state_next    = state;
    vc_resp       = 1'b0;
    vc_rdata_sel  = 1'b0;
    data_index    = '0;
    load_VC       = 1'b0;
    load_VC_dirty = 1'b0;
    VC_dirty_bit  = 1'b0;
    load_LRU      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_adr_sel  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (l2_write || l2_read) state_next = S_LOOKUP;
      end

      // Present the LRU way so that VC_LRU_dirty reflects the would-be victim
      // while the tag compare resolves in the same cycle.
      S_LOOKUP: begin
        data_index = lru_way(LRU_out);
        if (VC_hit)           state_next = S_HIT_UPD;
        else if (!op_write_q) state_next = S_READ_MEM;
        else if (VC_LRU_dirty) state_next = S_WRITEBACK;
        else                  state_next = S_INSERT;
      end

      // A write hit must never clean a dirty line. A clean re-eviction of a
      // line that is already dirty in the victim cache keeps it dirty.
      S_HIT_UPD: begin
        data_index   = hit_way_q;
        load_LRU     = 1'b1;
        vc_resp      = 1'b1;
        vc_rdata_sel = 1'b0;
        if (op_write_q) begin
          load_VC       = 1'b1;
          load_VC_dirty = 1'b1;
          VC_dirty_bit  = l2_dirty | hit_dirty_q;
        end
        state_next = S_IDLE;
      end

      // Read miss: memory data goes straight to L2 and is not allocated here.
      S_READ_MEM: begin
        pmem_read    = 1'b1;
        vc_rdata_sel = 1'b1;
        if (pmem_resp) begin
          vc_resp    = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_WRITEBACK: begin
        data_index   = victim_way_q;
        pmem_write   = 1'b1;
        pmem_adr_sel = 1'b1;
        if (pmem_resp) state_next = S_INSERT;
      end

      S_INSERT: begin
        data_index    = victim_way_q;
        load_VC       = 1'b1;
        load_VC_dirty = 1'b1;
        load_LRU      = 1'b1;
        VC_dirty_bit  = l2_dirty;
        vc_resp       = 1'b1;
        state_next    = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // L2 must hold the request that started this operation until vc_resp.
  a_req_held: assert property (
    @(posedge clk) disable iff (!reset_n)
    (state != S_IDLE) |-> (op_write_q ? l2_write : l2_read)
  );

endmodule

// File: tb/tb_vc_control.sv
// ---------------------------------------------------------------------------
// tb_vc_control
//   Directed, table-driven bench for vc_control. Each table row drives the
//   inputs for one clock cycle and gives the outputs expected in that cycle.
//   The expected outputs are packed as
//     {vc_resp, vc_rdata_sel, data_index[2:0], load_VC, load_VC_dirty,
//      VC_dirty_bit, load_LRU, pmem_read, pmem_write, pmem_adr_sel}.
//   Reset behaviour and the bounded post-reset response are hand-written.
// ---------------------------------------------------------------------------
module tb_vc_control;
  import vc_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        l2_read, l2_write, l2_dirty;
  logic        vc_resp, vc_rdata_sel;
  logic        VC_hit, VC_hit_dirty, VC_LRU_dirty;
  logic [2:0]  hit_way;
  logic [23:0] LRU_out;
  logic [2:0]  data_index;
  logic        load_VC, load_VC_dirty, VC_dirty_bit, load_LRU;
  logic        pmem_read, pmem_write, pmem_adr_sel, pmem_resp;

  int checks   = 0;
  int failures = 0;

  vc_control dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .l2_read       (l2_read),
    .l2_write      (l2_write),
    .l2_dirty      (l2_dirty),
    .vc_resp       (vc_resp),
    .vc_rdata_sel  (vc_rdata_sel),
    .VC_hit        (VC_hit),
    .VC_hit_dirty  (VC_hit_dirty),
    .VC_LRU_dirty  (VC_LRU_dirty),
    .hit_way       (hit_way),
    .LRU_out       (LRU_out),
    .data_index    (data_index),
    .load_VC       (load_VC),
    .load_VC_dirty (load_VC_dirty),
    .VC_dirty_bit  (VC_dirty_bit),
    .load_LRU      (load_LRU),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_adr_sel  (pmem_adr_sel),
    .pmem_resp     (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rd, wr, dty, hit, hdty, ldty;
    logic [2:0] hway, lway;
    logic       presp;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] pk(input logic resp, rsel, input logic [2:0] idx,
                                     input logic ldvc, lddty, dbit, ldlru,
                                     input logic prd, pwr, asel);
    return {resp, rsel, idx, ldvc, lddty, dbit, ldlru, prd, pwr, asel};
  endfunction

  function automatic vec_t mk(input logic rd, wr, dty, hit, hdty, ldty,
                              input logic [2:0] hway, lway, input logic presp,
                              input logic [11:0] exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.dty = dty; v.hit = hit; v.hdty = hdty; v.ldty = ldty;
    v.hway = hway; v.lway = lway; v.presp = presp; v.exp = exp;
    return v;
  endfunction

  function automatic logic [11:0] out_now();
    return {vc_resp, vc_rdata_sel, data_index, load_VC, load_VC_dirty,
            VC_dirty_bit, load_LRU, pmem_read, pmem_write, pmem_adr_sel};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %03h expected %03h", name, act, exp);
    end
  endtask

  // Non-zero upper stack bits catch a wrong slice of LRU_out.
  task automatic drive(input vec_t v);
    l2_read      = v.rd;
    l2_write     = v.wr;
    l2_dirty     = v.dty;
    VC_hit       = v.hit;
    VC_hit_dirty = v.hdty;
    VC_LRU_dirty = v.ldty;
    hit_way      = v.hway;
    LRU_out      = {21'h0ABCDE, v.lway};
    pmem_resp    = v.presp;
  endtask

  initial begin
    logic [11:0] z;
    int lat;
    z = 12'h000;

    // ---- reset state ----
    reset_n = 1'b0;
    drive(mk(0,1,1,0,0,0, 3'd0,3'd4, 1'b0, z));   // request present during reset
    #12 check("reset_outputs", out_now(), z);
    @(negedge clk);
    check("reset_held_idle", out_now(), z);
    l2_write = 1'b0;
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // ---- cycle table ----
    //             rd wr dty hit hdty ldty hway lway presp   resp rsel idx ldvc lddty dbit ldlru prd pwr asel
    // Dirty eviction into an empty cache: the LRU way 0 is clean.
    vecs.push_back(mk(0,1,1,0,0,0, 3'd0,3'd0, 0, z));
    vecs.push_back(mk(0,1,1,0,0,0, 3'd0,3'd0, 0, pk(0,0,3'd0,0,0,0,0,0,0,0)));
    vecs.push_back(mk(0,1,1,0,0,0, 3'd0,3'd0, 0, pk(1,0,3'd0,1,1,1,1,0,0,0)));
    // Read hit on way 0; LOOKUP shows LRU way 1, HIT_UPD shows the hit way.
    vecs.push_back(mk(1,0,0,1,1,0, 3'd0,3'd1, 0, z));
    vecs.push_back(mk(1,0,0,1,1,0, 3'd0,3'd1, 0, pk(0,0,3'd1,0,0,0,0,0,0,0)));
    vecs.push_back(mk(1,0,0,1,1,0, 3'd0,3'd1, 0, pk(1,0,3'd0,0,0,0,1,0,0,0)));
    vecs.push_back(mk(0,0,0,0,0,0, 3'd0,3'd1, 0, z));
    // Read miss; memory answers after 5 cycles; no load_* asserted.
    vecs.push_back(mk(1,0,0,0,0,0, 3'd0,3'd2, 0, z));
    vecs.push_back(mk(1,0,0,0,0,0, 3'd0,3'd2, 0, pk(0,0,3'd2,0,0,0,0,0,0,0)));
    vecs.push_back(mk(1,0,0,0,0,0, 3'd0,3'd2, 0, pk(0,1,3'd0,0,0,0,0,1,0,0)));
    vecs.push_back(mk(1,0,0,0,0,0, 3'd0,3'd2, 0, pk(0,1,3'd0,0,0,0,0,1,0,0)));
    vecs.push_back(mk(1,0,0,0,0,0, 3'd0,3'd2, 0, pk(0,1,3'd0,0,0,0,0,1,0,0)));
    vecs.push_back(mk(1,0,0,0,0,0, 3'd0,3'd2, 0, pk(0,1,3'd0,0,0,0,0,1,0,0)));
    vecs.push_back(mk(1,0,0,0,0,0, 3'd0,3'd2, 1, pk(1,1,3'd0,0,0,0,0,1,0,0)));
    // A stray pmem_resp in IDLE is ignored.
    vecs.push_back(mk(0,0,0,0,0,0, 3'd0,3'd2, 1, z));
    vecs.push_back(mk(0,0,0,0,0,0, 3'd0,3'd2, 0, z));
    // Clean eviction into a full cache whose LRU way 5 is dirty; the LRU stack
    // moves during the writeback, so the captured victim way must be used.
    vecs.push_back(mk(0,1,0,0,0,1, 3'd0,3'd5, 0, z));
    vecs.push_back(mk(0,1,0,0,0,1, 3'd0,3'd5, 0, pk(0,0,3'd5,0,0,0,0,0,0,0)));
    vecs.push_back(mk(0,1,0,0,0,1, 3'd0,3'd6, 0, pk(0,0,3'd5,0,0,0,0,0,1,1)));
    vecs.push_back(mk(0,1,0,0,0,1, 3'd0,3'd6, 0, pk(0,0,3'd5,0,0,0,0,0,1,1)));
    vecs.push_back(mk(0,1,0,0,0,1, 3'd0,3'd6, 1, pk(0,0,3'd5,0,0,0,0,0,1,1)));
    vecs.push_back(mk(0,1,0,0,0,1, 3'd0,3'd6, 0, pk(1,0,3'd5,1,1,0,1,0,0,0)));
    vecs.push_back(mk(0,0,0,0,0,0, 3'd0,3'd6, 0, z));
    // Clean write hit on dirty way 6: the dirty bit stays set.
    vecs.push_back(mk(0,1,0,1,1,0, 3'd6,3'd2, 0, z));
    vecs.push_back(mk(0,1,0,1,1,0, 3'd6,3'd2, 0, pk(0,0,3'd2,0,0,0,0,0,0,0)));
    vecs.push_back(mk(0,1,0,1,1,0, 3'd6,3'd2, 0, pk(1,0,3'd6,1,1,1,1,0,0,0)));
    vecs.push_back(mk(0,0,0,0,0,0, 3'd0,3'd2, 0, z));
    // Read and write together: the write completes first, then the read.
    vecs.push_back(mk(1,1,1,0,0,0, 3'd0,3'd4, 0, z));
    vecs.push_back(mk(1,1,1,0,0,0, 3'd0,3'd4, 0, pk(0,0,3'd4,0,0,0,0,0,0,0)));
    vecs.push_back(mk(1,1,1,0,0,0, 3'd0,3'd4, 0, pk(1,0,3'd4,1,1,1,1,0,0,0)));
    vecs.push_back(mk(1,0,1,1,0,0, 3'd7,3'd1, 0, z));
    vecs.push_back(mk(1,0,1,1,0,0, 3'd7,3'd1, 0, pk(0,0,3'd1,0,0,0,0,0,0,0)));
    vecs.push_back(mk(1,0,1,1,0,0, 3'd7,3'd1, 0, pk(1,0,3'd7,0,0,0,1,0,0,0)));
    vecs.push_back(mk(0,0,0,0,0,0, 3'd0,3'd1, 0, z));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), out_now(), vecs[i].exp);
      @(posedge clk); #1;
    end

    // ---- reset during WRITEBACK ----
    drive(mk(0,1,1,0,0,1, 3'd0,3'd3, 0, z));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("wb_before_reset", out_now(), pk(0,0,3'd3,0,0,0,0,0,1,1));
    #2 reset_n = 1'b0;
    #1 check("reset_async_clear", out_now(), z);
    l2_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_hold", out_now(), z);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Post-reset read hit; the response is expected two cycles after acceptance.
    drive(mk(1,0,0,1,0,0, 3'd2,3'd5, 0, z));
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (vc_resp) begin
        lat = c;
        break;
      end
    end
    check("post_reset_latency", 12'(lat), 12'd2);
    check("post_reset_hit", out_now(), pk(1,0,3'd2,0,0,0,1,0,0,0));
    @(posedge clk); #1;
    l2_read = 1'b0;
    @(negedge clk);
    check("post_reset_idle", out_now(), z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_control.md
# vc_control

Sequencing controller for the 8-way fully-associative victim cache between the L2 cache and physical memory. Accepts line-granular read lookups and dirty/clean evictions from L2, drives the victim-cache datapath's way index and write enables, and issues writebacks or line fills to physical memory. The victim cache is victim-only: read misses are not allocated; only L2 evictions are inserted.

## Interface
Parameters:
- none (way count 8, line 128 bits, line address 12 bits, fixed via lc3b_types)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- l2_read  in  1  L2 read lookup request, held until vc_resp
- l2_write  in  1  L2 eviction into victim cache, held until vc_resp
- l2_dirty  in  1  dirty flag of the evicted line (valid with l2_write)
- vc_resp  out  1  one-cycle completion pulse to L2
- vc_rdata_sel  out  1  L2 return-data source: 0 = victim-cache hit way, 1 = pmem data
- VC_hit  in  1  datapath tag match for current L2 address
- VC_hit_dirty  in  1  dirty bit of matching way
- VC_LRU_dirty  in  1  dirty bit of way selected by data_index
- hit_way  in  3  matching way number
- LRU_out  in  24  LRU stack; bits [23:21] MRU way, bits [2:0] LRU way
- data_index  out  3  way select to datapath
- load_VC  out  1  write data/address/valid of data_index way
- load_VC_dirty  out  1  write dirty bit of data_index way
- VC_dirty_bit  out  1  dirty value to write
- load_LRU  out  1  promote data_index to MRU
- pmem_read  out  1  memory line read, held until pmem_resp
- pmem_write  out  1  memory line write of wb_address/wb_data, held until pmem_resp
- pmem_adr_sel  out  1  memory address source: 0 = L2 address, 1 = datapath wb_address
- pmem_resp  in  1  memory completion

## Operation
- States: IDLE, LOOKUP, HIT_UPD, READ_MEM, WRITEBACK, INSERT.
- IDLE: on l2_write -> LOOKUP (write has priority if both asserted; read stays pending); else on l2_read -> LOOKUP.
- LOOKUP (1 cycle): data_index = LRU_out[2:0]. Register hit_way, VC_hit_dirty, LRU way, VC_LRU_dirty, op type.
  - hit -> HIT_UPD.
  - read miss -> READ_MEM.
  - write miss, victim dirty -> WRITEBACK; victim clean -> INSERT.
- HIT_UPD (1 cycle): data_index = registered hit way; load_LRU = 1; vc_resp = 1; vc_rdata_sel = 0. For writes also load_VC = 1, load_VC_dirty = 1, VC_dirty_bit = l2_dirty | registered hit dirty. -> IDLE.
- READ_MEM: pmem_read = 1, pmem_adr_sel = 0, vc_rdata_sel = 1; on pmem_resp: vc_resp = 1 same cycle, -> IDLE. No VC state change.
- WRITEBACK: data_index = registered victim way; pmem_write = 1, pmem_adr_sel = 1; on pmem_resp -> INSERT.
- INSERT (1 cycle): data_index = registered victim way; load_VC, load_VC_dirty, load_LRU = 1; VC_dirty_bit = l2_dirty; vc_resp = 1. -> IDLE.
- All outputs not listed for a state are 0; data_index defaults to 0.

## Timing
- Reset: state = IDLE; every output 0; registered way/dirty/op cleared. Reset mid-operation aborts immediately; pmem request dropped; datapath arrays not reset.
- Request accepted in IDLE at cycle t: LOOKUP t+1; hit response t+2; clean-miss insert response t+2.
- Read miss: pmem_read from t+2; vc_resp in the pmem_resp cycle.
- Dirty write miss: pmem_write from t+2; INSERT and vc_resp the cycle after pmem_resp.
- pmem_resp outside READ_MEM/WRITEBACK ignored. Dropping l2_read/l2_write before vc_resp is illegal (assertion).
- Back-to-back: a new request is accepted no earlier than the cycle after vc_resp (IDLE).

## Structure
- lc3b_types gains: VC_WAYS = 8, vc_way_t (3-bit), vc_state_t enum, function lru_way(LRU_out) returning bits [2:0].
- Single module, one always_ff state/registers block, one always_comb output/next-state block. No sub-module; top wrapper vc_top instances vc_control with the datapath.

## Test plan
- Reset then write addr 0x010 dirty to empty VC: LRU way 0 clean -> INSERT at t+2, load_VC/load_VC_dirty/load_LRU with data_index 0, VC_dirty_bit 1, vc_resp.
- Read 0x010 after above: HIT_UPD t+2, data_index 0, load_LRU only, vc_rdata_sel 0, vc_resp.
- Read 0x0FF miss: pmem_read from t+2, hold 5 cycles, vc_resp with pmem_resp, no load_* asserted.
- Fill 8 ways dirty, write 0x123: WRITEBACK of LRU way with pmem_adr_sel 1; after pmem_resp, INSERT into same way, VC_dirty_bit = l2_dirty.
- Clean write hit on dirty way: VC_dirty_bit stays 1; l2_read and l2_write together: write serviced first.
- reset_n low during WRITEBACK: all outputs 0 asynchronously; post-reset read proceeds from IDLE normally.
